// File: rtl/bnn_pkg.sv
// Shared BNN datapath definitions: top-level sequencing states, the
// layer-local state encoding, kernel geometry and the popcount helper.
package bnn_pkg;

    typedef enum logic [2:0] {
        s_IDLE,
        s_LOAD,
        s_LAYER_1,
        s_LAYER_2,
        s_LAYER_3
    } state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_RUN,
        L_FLUSH
    } layer_state_t;

    localparam int KERNEL = 3;
    localparam int POP_W  = 4;

    // Number of set bits in a flattened 3x3 window (0..9).
    function automatic logic [POP_W-1:0] popcount9(input logic [KERNEL*KERNEL-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < KERNEL*KERNEL; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bnn_xnor_pop3x3.sv
// 3x3 binary match counter: popcount of XNOR between a pixel window and a kernel.
module bnn_xnor_pop3x3
    import bnn_pkg::*;
(
    input  logic [KERNEL-1:0][KERNEL-1:0] window,
    input  logic [KERNEL-1:0][KERNEL-1:0] kernel,
    output logic [POP_W-1:0]              match
);

    // A tap matches when pixel and weight agree.
    always_comb begin
        match = popcount9(~(window ^ kernel));
    end

endmodule

// File: rtl/bnn_conv_pool_layer.sv
// Binary 3x3 convolution layer with per-channel threshold and optional 2x2
// OR-pool, streaming one activation bit per handshake.
// Build option: define BNN_POOL_EN to enable 2x2 pooling (OUT_DIM = IMG_DIM/2).
module bnn_conv_pool_layer
    import bnn_pkg::*;
#(
    parameter int IMG_DIM = 28,
    parameter int NUM_CH  = 8,
`ifdef BNN_POOL_EN
    localparam int OUT_DIM = IMG_DIM / 2
`else
    localparam int OUT_DIM = IMG_DIM
`endif
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [IMG_DIM-1:0][IMG_DIM-1:0]        pixels,
    input  logic [NUM_CH-1:0][KERNEL-1:0][KERNEL-1:0] weights,
    input  logic [NUM_CH-1:0][3:0]                 thresholds,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_bit,
    output logic [$clog2(NUM_CH)-1:0]              out_ch,
    output logic [$clog2(OUT_DIM)-1:0]             out_row,
    output logic [$clog2(OUT_DIM)-1:0]             out_col,
    output logic                                   done
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int RC_W = $clog2(OUT_DIM);
    localparam int PAD  = IMG_DIM + 2;
    localparam int PW   = $clog2(PAD);
`ifdef BNN_POOL_EN
    localparam int NPOS = 4;
    localparam int STEP = 2;
`else
    localparam int NPOS = 1;
    localparam int STEP = 1;
`endif

    layer_state_t state_q, state_d;
    logic [IMG_DIM-1:0][IMG_DIM-1:0]           pix_q, pix_d;
    logic [NUM_CH-1:0][KERNEL-1:0][KERNEL-1:0] wgt_q, wgt_d;
    logic [NUM_CH-1:0][3:0]                    thr_q, thr_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [RC_W-1:0] row_q, row_d, col_q, col_d;
    logic            busy_q, busy_d, out_valid_q, out_valid_d, out_bit_q, out_bit_d, done_q, done_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [RC_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;

    logic [PAD-1:0][PAD-1:0]                 pad;
    logic [NPOS-1:0][KERNEL-1:0][KERNEL-1:0] win;
    logic [NPOS-1:0][POP_W-1:0]              match;
    logic [NPOS-1:0]                         act;
    logic [KERNEL-1:0][KERNEL-1:0]           kern;
    logic [3:0]                              thr_cur;
    logic                                    result;

    // Zero border around the snapshot so edge windows read out-of-image taps as 0.
    always_comb begin
        pad = '0;
        for (int unsigned r = 0; r < IMG_DIM; r++) begin
            pad[r+1] = {1'b0, pix_q[r], 1'b0};
        end
    end

    // Gather the 3x3 window(s) for the current output coordinate.
    // Pad row/col y+k holds image row/col y+k-1, so tap (kr,kc) sits at pad[y+kr][x+kc].
    always_comb begin
        win = '0;
        for (int unsigned p = 0; p < NPOS; p++) begin
            for (int unsigned kr = 0; kr < KERNEL; kr++) begin
                for (int unsigned kc = 0; kc < KERNEL; kc++) begin
                    win[p][kr][kc] = pad[PW'(32'(row_q) * STEP + p / 2 + kr)]
                                        [PW'(32'(col_q) * STEP + p % 2 + kc)];
                end
            end
        end
    end

    for (genvar p = 0; p < NPOS; p++) begin : g_pop
        bnn_xnor_pop3x3 u_pop (
            .window (win[p]),
            .kernel (kern),
            .match  (match[p])
        );
    end

    // Threshold each window and OR them together (a single term without pooling).
    always_comb begin
        kern    = wgt_q[ch_q];
        thr_cur = thr_q[ch_q];
        for (int unsigned p = 0; p < NPOS; p++) begin
            act[p] = (match[p] >= thr_cur);
        end
        result = |act;
    end

    // Layer sequencing: snapshot on start, walk col/row/ch, drain the last result.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        wgt_d       = wgt_q;
        thr_d       = thr_q;
        ch_d        = ch_q;
        row_d       = row_q;
        col_d       = col_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_ch_d    = out_ch_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        done_d      = 1'b0;
        case (state_q)
            L_IDLE: begin
                // done_q high means the previous pass ended this cycle; a start now is dropped.
                if (start && !done_q) begin
                    pix_d   = pixels;
                    wgt_d   = weights;
                    thr_d   = thresholds;
                    ch_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    state_d = L_RUN;
                end
            end
            L_RUN: begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_bit_d   = result;
                    out_ch_d    = ch_q;
                    out_row_d   = row_q;
                    out_col_d   = col_q;
                    if (col_q == RC_W'(OUT_DIM - 1)) begin
                        col_d = '0;
                        if (row_q == RC_W'(OUT_DIM - 1)) begin
                            row_d = '0;
                            if (ch_q == CH_W'(NUM_CH - 1)) begin
                                state_d = L_FLUSH;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            L_FLUSH: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = L_IDLE;
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    // State and output registers; reset aborts any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= L_IDLE;
            pix_q       <= '0;
            wgt_q       <= '0;
            thr_q       <= '0;
            ch_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_ch_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            wgt_q       <= wgt_d;
            thr_q       <= thr_d;
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_ch_q    <= out_ch_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_ch    = out_ch_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bnn_conv_pool_layer.sv
// Directed bench for bnn_conv_pool_layer: vector table of image/kernel/threshold
// patterns checked against a tap-by-tap reference, plus stall, restart and abort sequences.
module tb_bnn_conv_pool_layer;

    localparam int IMG = 28;
    localparam int NCH = 8;
`ifdef BNN_POOL_EN
    localparam int  OUT_DIM = IMG / 2;
    localparam bit  POOL    = 1'b1;
`else
    localparam int  OUT_DIM = IMG;
    localparam bit  POOL    = 1'b0;
`endif
    localparam int CH_W  = $clog2(NCH);
    localparam int RC_W  = $clog2(OUT_DIM);
    localparam int TOTAL = NCH * OUT_DIM * OUT_DIM;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic [IMG-1:0][IMG-1:0]       pixels_in;
    logic [NCH-1:0][2:0][2:0]      weights_in;
    logic [NCH-1:0][3:0]           thresholds_in;
    logic busy, out_valid, out_bit, done;
    logic [CH_W-1:0] out_ch;
    logic [RC_W-1:0] out_row, out_col;

    // Reference copies of the pass data (the DUT inputs get scrambled after start).
    logic [IMG-1:0][IMG-1:0]  img;
    logic [NCH-1:0][2:0][2:0] w_tb;
    logic [NCH-1:0][3:0]      thr_tb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        int         pix_mode;   // 0 zero, 1 ones, 2 single (0,0), 3 mixed pattern
        bit         w_fill;
        logic [3:0] thr0;
        logic [3:0] thr_rest;
        bit         stall;
        bit         restart;
        int         ones_pool;  // -1: ones count not checked
        int         ones_flat;
    } vec_t;

    vec_t vecs[7];

    bnn_conv_pool_layer #(.IMG_DIM(IMG), .NUM_CH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pixels     (pixels_in),
        .weights    (weights_in),
        .thresholds (thresholds_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_ch     (out_ch),
        .out_row    (out_row),
        .out_col    (out_col),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic bit model_act(input int ch, input int y, input int x);
        int cnt = 0;
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                int  py = y + kr - 1;
                int  px = x + kc - 1;
                bit  p  = 1'b0;
                if (py >= 0 && py < IMG && px >= 0 && px < IMG) p = img[py][px];
                if (p == w_tb[ch][kr][kc]) cnt++;
            end
        end
        return cnt >= int'(thr_tb[ch]);
    endfunction

    function automatic bit model_bit(input int ch, input int r, input int c);
        if (POOL)
            return model_act(ch, 2*r, 2*c) | model_act(ch, 2*r, 2*c+1) |
                   model_act(ch, 2*r+1, 2*c) | model_act(ch, 2*r+1, 2*c+1);
        return model_act(ch, r, c);
    endfunction

    task automatic load_vec(input vec_t v);
        img = '0;
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                case (v.pix_mode)
                    1:       img[r][c] = 1'b1;
                    2:       img[r][c] = (r == 0 && c == 0);
                    3:       img[r][c] = (((r*3 + c*5 + r*c) % 7) < 3);
                    default: img[r][c] = 1'b0;
                endcase
        for (int ch = 0; ch < NCH; ch++) begin
            if (v.pix_mode == 3) begin
                w_tb[ch]   = 9'(ch*83 + 45);
                thr_tb[ch] = 4'(ch + 2);
            end else begin
                w_tb[ch]   = v.w_fill ? 9'h1FF : 9'h000;
                thr_tb[ch] = (ch == 0) ? v.thr0 : v.thr_rest;
            end
        end
        pixels_in     = img;
        weights_in    = w_tb;
        thresholds_in = thr_tb;
    endtask

    task automatic do_start(input string nm);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, ":busy_after_start"}, int'(busy), 1);
        check({nm, ":valid_not_yet"}, int'(out_valid), 0);
        // Inputs are free to change once the snapshot is taken.
        pixels_in     = ~pixels_in;
        weights_in    = ~weights_in;
        thresholds_in = ~thresholds_in;
    endtask

    task automatic run_pass(input string nm, input bit stall_en, input bit restart_en,
                            input int abort_at, input int exp_ones);
        int hs = 0, ech = 0, er = 0, ec = 0, dones = 0, cyc = 0, last_hs = 0;
        int stall = 0, ones = 0, held = 0, extra = 0, got = 0, expv = 0;
        bit fin = 1'b0, aborted = 1'b0;
        do_start(nm);
        while (!fin && cyc < TOTAL + 200) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            out_ready = !(stall_en && hs == 3 && stall < 5);
            got = int'({out_bit, out_ch, out_row, out_col});
            if (cyc == 1) check({nm, ":first_valid"}, int'(out_valid), 1);
            if (done) begin
                dones++;
                check({nm, ":done_timing"}, cyc - last_hs, 1);
                check({nm, ":valid_low_at_done"}, int'(out_valid), 0);
                if (restart_en) start = 1'b1;
                fin = 1'b1;
            end else if (!out_ready) begin
                check({nm, ":stall_valid"}, int'(out_valid), 1);
                if (stall == 0) held = got;
                else            check({nm, ":stall_hold"}, got, held);
                stall++;
            end else if (out_valid) begin
                expv = int'({model_bit(ech, er, ec), CH_W'(ech), RC_W'(er), RC_W'(ec)});
                check({nm, ":stream"}, got, expv);
                ones += int'(out_bit);
                hs++;
                last_hs = cyc;
                ec++;
                if (ec == OUT_DIM) begin
                    ec = 0;
                    er++;
                    if (er == OUT_DIM) begin
                        er = 0;
                        ech++;
                    end
                end
                if (restart_en && hs == 50) start = 1'b1;
                if (hs == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check({nm, ":abort_state"},
                          int'({busy, out_valid, done, out_bit, out_ch, out_row, out_col}), 0);
                    rst = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        @(negedge clk);
                        extra += int'(done) + int'(out_valid) + int'(busy);
                    end
                    check({nm, ":abort_quiet"}, extra, 0);
                    aborted = 1'b1;
                    fin     = 1'b1;
                end
            end
        end
        if (!fin) check({nm, ":completed_in_budget"}, 0, 1);
        if (fin && !aborted) begin
            check({nm, ":handshakes"}, hs, TOTAL);
            check({nm, ":done_count"}, dones, 1);
            if (exp_ones >= 0) check({nm, ":ones"}, ones, exp_ones);
            @(negedge clk);
            start = 1'b0;
            check({nm, ":idle_after_done"}, int'(busy), 0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                extra += int'(done) + int'(out_valid);
            end
            check({nm, ":quiet_after_done"}, extra, 0);
        end
    endtask

    initial begin
        vecs[0] = '{"zero_w0_t9",  0, 1'b0, 4'd9,  4'd9,  1'b1, 1'b0, 1568, 6272};
        vecs[1] = '{"zero_w1_t1",  0, 1'b1, 4'd1,  4'd1,  1'b0, 1'b1,    0,    0};
        vecs[2] = '{"ones_w1_t9",  1, 1'b1, 4'd9,  4'd9,  1'b0, 1'b0, 1568, 5408};
        vecs[3] = '{"zero_w1_t0",  0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1568, 6272};
        vecs[4] = '{"zero_w0_t10", 0, 1'b0, 4'd10, 4'd10, 1'b0, 1'b0,    0,    0};
        vecs[5] = '{"single_px",   2, 1'b1, 4'd1,  4'd10, 1'b0, 1'b0,    1,    4};
        vecs[6] = '{"mixed",       3, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0,   -1,   -1};

        rst           = 1'b1;
        start         = 1'b0;
        out_ready     = 1'b1;
        pixels_in     = '0;
        weights_in    = '0;
        thresholds_in = '0;
        repeat (2) @(negedge clk);
        check("reset_state", int'({busy, out_valid, done, out_bit, out_ch, out_row, out_col}), 0);
        rst = 1'b0;

        // Abort a pass after result 100; the following pass must restart at ch0/row0/col0.
        load_vec(vecs[6]);
        run_pass("abort", 1'b0, 1'b0, 100, -1);

        for (int i = 0; i < 7; i++) begin
            load_vec(vecs[i]);
            run_pass(vecs[i].name, vecs[i].stall, vecs[i].restart, -1,
                     POOL ? vecs[i].ones_pool : vecs[i].ones_flat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bnn_conv_pool_layer.md
# bnn_conv_pool_layer

Parametrised binary convolution layer for the MNIST BNN datapath: applies NUM_CH 3x3 binary kernels to a 1-bit IMG_DIM x IMG_DIM image (zero padding, stride 1). Each output is a popcount-of-XNOR compared against a runtime per-channel threshold, optionally followed by 2x2 max-pool. Results stream out one bit per cycle over a valid/ready handshake. The block sits between the image loader and layer two and runs when the top-level FSM issues start.

## Interface
- IMG_DIM, 28, input image side; must be even and >= 4
- NUM_CH, 8, number of kernels / output channels
- OUT_DIM, IMG_DIM/2 with pooling, IMG_DIM without (derived, localparam)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- pixels  in  [IMG_DIM-1:0][IMG_DIM-1:0]  binary image, 1 = ink
- weights  in  [NUM_CH-1:0][2:0][2:0]  binary kernels, [ch][kr][kc]
- thresholds  in  [NUM_CH-1:0][3:0]  per-channel match-count threshold
- busy  out  1  high from accepted start until done
- out_valid  out  1  output bit and coordinates valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_bit  out  1  activation
- out_ch  out  $clog2(NUM_CH)  channel index
- out_row, out_col  out  $clog2(OUT_DIM) each  output coordinates
- done  out  1  one-cycle pulse at pass end

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: on start, snapshot pixels, weights and thresholds into internal registers. Clear indices ch/row/col to 0 and go to RUN. Inputs may change after that.
- RUN: the index triple walks col fastest, then row, then ch. It advances only when the output register is free (!out_valid | out_ready). On that condition, load the result for the current triple into the output register, set out_valid, and increment.
- After the triple (NUM_CH-1, OUT_DIM-1, OUT_DIM-1) is loaded, go to FLUSH.
- FLUSH: wait for the final handshake. Then pulse done for one cycle, drop busy, and return to IDLE.
- Convolution at (r,c): 9 taps. A tap is a match when pixel XNOR weight = 1. Out-of-image pixels read as 0.
- match = popcount (0..9, 4 bits). Activation = (match >= thresholds[ch]), unsigned 4-bit compare. A threshold of 0 always fires; a threshold of 10..15 never fires.
- Pooling: out_bit is the OR of the activations at (2r,2c), (2r,2c+1), (2r+1,2c) and (2r+1,2c+1).
- out_bit, out_ch, out_row and out_col hold stable while out_valid & !out_ready.
- start is ignored while busy. A start arriving in the same cycle as the done pulse is ignored.

## Timing
- Reset values: busy 0, out_valid 0, done 0, out_bit 0, out_ch/out_row/out_col 0, state IDLE.
- rst mid-pass aborts immediately. On the next edge every output takes its reset value; no done is produced.
- start accepted at edge E0. busy is high after E0 and the first out_valid is high after E1.
- With out_ready held high: one result per cycle, NUM_CH*OUT_DIM*OUT_DIM handshakes, and done high in the cycle after the last handshake.
- The convolution/pool path is combinational from the snapshot registers into the output register, giving a single-stage latency.

## Configuration
- BNN_POOL_EN defined: 2x2 OR-pool active, OUT_DIM = IMG_DIM/2 (14x14 per channel at default).
- BNN_POOL_EN undefined: no pooling. OUT_DIM = IMG_DIM, out_bit is the activation at (row,col), and the pass length becomes NUM_CH*IMG_DIM².

## Structure
- Shared package bnn_pkg: the state_t top-level enum (s_IDLE .. s_LAYER_3), the layer-local state enum, the KERNEL = 3 constant, and the popcount width constant.
- One sub-module: bnn_xnor_pop3x3. Inputs are a 3x3 pixel window and a 3x3 kernel; output is a 4-bit match count.
- Instantiate bnn_xnor_pop3x3 four times with pooling, once without.

## Test plan
- All pixels 0, all weights 0, thresholds all 9 -> every out_bit = 1; 1568 handshakes at default; done pulses once.
- All pixels 0, all weights 1, thresholds all 1 -> every out_bit = 0.
- Single pixel (0,0) = 1, ch0 weights all 1, threshold 1 -> ch0 (0,0) = 1. ch0 (0,1), (1,0) and all other ch0 outputs = 0.
- out_ready low for 5 cycles at the 4th result -> out_valid stays 1 and out_bit/out_ch/out_row/out_col are unchanged; the stream resumes with no skipped or duplicated index.
- rst asserted after result 100 -> next cycle out_valid = 0, busy = 0, no done. A new start emits ch0/row0/col0 first.
- Second start pulse while busy -> ignored. The pass length and the single done pulse are unchanged.
